// File: rtl/execute_muldiv_unit_if.sv
// Operand/result handshake bundle for the execute-stage multiply/divide unit.
// master = pipeline side, slave = the unit.
interface execute_muldiv_unit_if #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_funct3;
    logic [XLEN-1:0]      in_rs1;
    logic [XLEN-1:0]      in_rs2;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_result;
    logic [TAG_WIDTH-1:0] out_tag;

    modport master (
        output flush, in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  flush, in_valid, in_funct3, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divides stay iterative).
module execute_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    execute_muldiv_unit_if.slave  mdu
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           f3_q, f3_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]      opa_q, opa_d;
    logic [XLEN-1:0]      hi_q, hi_d;
    logic [XLEN-1:0]      lo_q, lo_d;
    logic [XLEN:0]        rem_q, rem_d;
    logic [XLEN-1:0]      res_q, res_d;

    logic                 acc;
    logic                 is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic                 div_zero, ovf, fast_take;
    logic [XLEN-1:0]      a_abs, b_abs, fast_res;

    logic [XLEN:0]        sum;
    logic [2*XLEN-1:0]    prod_nx, prod_s;
    logic [XLEN+1:0]      sh, trial;
    logic [XLEN:0]        rem_nx;
    logic [XLEN-1:0]      lo_nx, q_s, r_s, calc_res;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]    ma, mb, mp;
`endif

    assign mdu.in_ready   = (state_q == IDLE) && !mdu.flush && !rst;
    assign mdu.out_valid  = (state_q == DONE);
    assign mdu.out_result = res_q;
    assign mdu.out_tag    = tag_q;
    assign acc            = mdu.in_valid && mdu.in_ready;

    // Operand decode: signedness, magnitudes and fast-path detection.
    always_comb begin
        is_div   = mdu.in_funct3[2];
        a_sgn    = 1'b0;
        b_sgn    = 1'b0;
        unique case (mdu.in_funct3)
            3'd1, 3'd4, 3'd6: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'd2:             a_sgn = 1'b1;
            default:          ;
        endcase
        a_neg    = a_sgn & mdu.in_rs1[XLEN-1];
        b_neg    = b_sgn & mdu.in_rs2[XLEN-1];
        a_abs    = a_neg ? -mdu.in_rs1 : mdu.in_rs1;
        b_abs    = b_neg ? -mdu.in_rs2 : mdu.in_rs2;
        div_zero = (mdu.in_rs2 == '0);
        ovf      = mdu.in_funct3[2] && !mdu.in_funct3[0]
                && (mdu.in_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                && (mdu.in_rs2 == '1);
        if (div_zero)
            fast_res = mdu.in_funct3[1] ? mdu.in_rs1 : '1;
        else
            fast_res = mdu.in_funct3[1] ? '0 : mdu.in_rs1;
`ifdef MULDIV_FAST_MUL_EN
        ma = {{XLEN{a_sgn & mdu.in_rs1[XLEN-1]}}, mdu.in_rs1};
        mb = {{XLEN{b_sgn & mdu.in_rs2[XLEN-1]}}, mdu.in_rs2};
        mp = ma * mb;
        fast_take = is_div ? (div_zero | ovf) : 1'b1;
        if (!is_div)
            fast_res = (mdu.in_funct3 == 3'd0) ? mp[XLEN-1:0] : mp[2*XLEN-1:XLEN];
`else
        fast_take = is_div & (div_zero | ovf);
`endif
    end

    // One iteration of shift-add / restoring divide plus final sign fix-up.
    always_comb begin
        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
        prod_nx  = {sum, lo_q[XLEN-1:1]};
        prod_s   = (sa_q ^ sb_q) ? -prod_nx : prod_nx;
        sh       = {rem_q, lo_q[XLEN-1]};
        trial    = sh - {2'b00, opa_q};
        rem_nx   = trial[XLEN+1] ? sh[XLEN:0] : trial[XLEN:0];
        lo_nx    = {lo_q[XLEN-2:0], ~trial[XLEN+1]};
        q_s      = (sa_q ^ sb_q) ? -lo_nx : lo_nx;
        r_s      = sa_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
        if (f3_q[2])
            calc_res = f3_q[1] ? r_s : q_s;
        else if (f3_q == 3'd0)
            calc_res = prod_s[XLEN-1:0];
        else
            calc_res = prod_s[2*XLEN-1:XLEN];
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        tag_d   = tag_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        opa_d   = opa_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    f3_d  = mdu.in_funct3;
                    tag_d = mdu.in_tag;
                    sa_d  = a_neg;
                    sb_d  = b_neg;
                    hi_d  = '0;
                    rem_d = '0;
                    cnt_d = '0;
                    opa_d = is_div ? b_abs : a_abs;
                    lo_d  = is_div ? a_abs : b_abs;
                    if (fast_take) begin
                        res_d   = fast_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (f3_q[2]) begin
                    lo_d  = lo_nx;
                    rem_d = rem_nx;
                end else begin
                    hi_d = prod_nx[2*XLEN-1:XLEN];
                    lo_d = prod_nx[XLEN-1:0];
                end
                if (cnt_q == CW'(XLEN-1)) begin
                    res_d   = calc_res;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (mdu.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (mdu.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            tag_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opa_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            tag_q   <= tag_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            opa_q   <= opa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Directed testbench for execute_muldiv_unit (XLEN=32).
// Expected values are hand-computed constants.
module tb_execute_muldiv_unit;
    localparam int XLEN = 32;
    localparam int TW   = 5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    execute_muldiv_unit_if #(.XLEN(XLEN), .TAG_WIDTH(TW)) bus ();

    execute_muldiv_unit #(.XLEN(XLEN), .TAG_WIDTH(TW)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
        @(negedge clk);
        chk("accept_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f;
        bus.in_rs1    = a;
        bus.in_rs2    = b;
        bus.in_tag    = t;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_rs1    = 32'hDEAD_BEEF;
        bus.in_rs2    = 32'h0BAD_F00D;
        bus.in_tag    = 5'h1F;
    endtask

    task automatic wait_valid(output int lat, output bit busy_low);
        lat      = 0;
        busy_low = 1'b1;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid === 1'b1) break;
            if (bus.in_ready !== 1'b0) busy_low = 1'b0;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic op(input string name, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] t,
                      input logic [31:0] exp, input int exp_lat);
        int lat;
        bit bl;
        send(f, a, b, t);
        wait_valid(lat, bl);
        chk({name, "_res"}, 64'(bus.out_result), 64'(exp));
        chk({name, "_tag"}, 64'(bus.out_tag), 64'(t));
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy"}, 64'(bl), 64'd1);
        take();
    endtask

    task automatic watch_quiet(input string name);
        bit seen;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        int lat;
        bit bl;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_funct3 = 3'd0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.out_result), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

        op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
        op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, MUL_LAT);
        op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, MUL_LAT);
        op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, MUL_LAT);
        op("mul_big", 3'd0, 32'h0001_0003, 32'h0002_0005, 5'd4, 32'h000B_000F, MUL_LAT);

        op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, DIV_LAT);
        op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, DIV_LAT);
        op("divu", 3'd5, 32'd100, 32'd7, 5'd8, 32'd14, DIV_LAT);
        op("remu", 3'd7, 32'd100, 32'd7, 5'd9, 32'd2, DIV_LAT);
        op("div_negdiv", 3'd4, 32'd100, 32'hFFFF_FFF9, 5'd10, 32'hFFFF_FFF2, DIV_LAT);

        op("divu_z", 3'd5, 32'h1234, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
        op("rem_z", 3'd6, 32'h1234, 32'd0, 5'd12, 32'h0000_1234, 1);
        op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
        op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 1);

        send(3'd5, 32'd100, 32'd7, 5'd20);
        wait_valid(lat, bl);
        chk("bp_lat", 64'(lat), 64'(DIV_LAT));
        repeat (5) begin
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_result", 64'(bus.out_result), 64'd14);
            chk("bp_tag", 64'(bus.out_tag), 64'd20);
            chk("bp_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        take();
        op("b2b", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12, MUL_LAT);

        send(3'd4, 32'd100, 32'd7, 5'd22);
        repeat (10) @(negedge clk);
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_funct3 = 3'd5;
        bus.in_rs1    = 32'd9;
        bus.in_rs2    = 32'd0;
        bus.in_tag    = 5'd23;
        #1;
        chk("flush_calc_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_ready_after", 64'(bus.in_ready), 64'd1);
        chk("flush_valid_after", 64'(bus.out_valid), 64'd0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        chk("flush_idle_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        watch_quiet("flush_quiet");
        op("after_flush", 3'd5, 32'd9, 32'd3, 5'd24, 32'd3, DIV_LAT);

        send(3'd4, 32'd100, 32'd7, 5'd25);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_result", 64'(bus.out_result), 64'd0);
        chk("rst_mid_tag", 64'(bus.out_tag), 64'd0);
        watch_quiet("rst_quiet");
        op("after_rst", 3'd5, 32'd9, 32'd3, 5'd26, 32'd3, DIV_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
